// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: opcodes, ALU op encodings, forwarding selects
// and the ID/EX control payload.
package mips_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned FWD_W    = 2;

  localparam logic [OPCODE_W-1:0] R_TYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] LW     = 6'b100011;
  localparam logic [OPCODE_W-1:0] SW     = 6'b101011;
  localparam logic [OPCODE_W-1:0] BEQ    = 6'b000100;
  localparam logic [OPCODE_W-1:0] ADDI   = 6'b001000;
  localparam logic [OPCODE_W-1:0] JMP    = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_AND   = 3'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'd4;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'd5;

  typedef enum logic [FWD_W-1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Single-bit decoder controls carried from ID into EX
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
    logic alusrc;
    logic regdst;
  } ex_ctrl_t;

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard detection: load-use and branch stalls, redirect flush,
// and forwarding selects for the ID comparator and the EX ALU operands.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              i_branch_d,
  input  logic              i_jump_d,
  input  logic              i_equal_d,
  input  logic [REG_AW-1:0] i_rs_d,
  input  logic [REG_AW-1:0] i_rt_d,
  input  logic [REG_AW-1:0] i_rs_e,
  input  logic [REG_AW-1:0] i_rt_e,
  input  logic              i_regwrite_e,
  input  logic              i_memtoreg_e,
  input  logic [REG_AW-1:0] i_writereg_e,
  input  logic              i_regwrite_m,
  input  logic              i_memtoreg_m,
  input  logic [REG_AW-1:0] i_writereg_m,
  input  logic              i_regwrite_w,
  input  logic [REG_AW-1:0] i_writereg_w,
  output logic              o_pcsrc_d_c,
  output logic              o_stall_c,
  output logic              o_flush_d_c,
  output logic              o_fwd_a_d_c,
  output logic              o_fwd_b_d_c,
  output logic [FWD_W-1:0]  o_fwd_a_e_c,
  output logic [FWD_W-1:0]  o_fwd_b_e_c
);

  // Register 0 is hardwired, so a source of $0 never depends on anything
  function automatic logic hit(input logic wr, input logic [REG_AW-1:0] dst,
                               input logic [REG_AW-1:0] src);
    return wr && (src != '0) && (dst == src);
  endfunction

  function automatic logic [FWD_W-1:0] fwd_e(input logic [REG_AW-1:0] src,
                                             input logic wr_m, input logic [REG_AW-1:0] dst_m,
                                             input logic wr_w, input logic [REG_AW-1:0] dst_w);
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (hit(wr_m, dst_m, src)) begin
      sel = FWD_MEM;
    end else if (hit(wr_w, dst_w, src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  logic w_lwstall;
  logic w_brstall;
  logic w_stall;
  logic w_pcsrc;

  always_comb begin
    w_lwstall = 1'b0;
    w_brstall = 1'b0;
    w_lwstall = hit(i_memtoreg_e, i_rt_e, i_rs_d) || hit(i_memtoreg_e, i_rt_e, i_rt_d);
    // Branch compares in ID, so it must wait for any producer still in EX or a load in MEM
    w_brstall = i_branch_d &&
                (hit(i_regwrite_e, i_writereg_e, i_rs_d) || hit(i_regwrite_e, i_writereg_e, i_rt_d) ||
                 hit(i_memtoreg_m, i_writereg_m, i_rs_d) || hit(i_memtoreg_m, i_writereg_m, i_rt_d));
  end

  always_comb begin
    w_stall     = w_lwstall || w_brstall;
    w_pcsrc     = i_branch_d && i_equal_d;
    o_stall_c   = w_stall;
    o_pcsrc_d_c = w_pcsrc;
    o_flush_d_c = (w_pcsrc || i_jump_d) && !w_stall;
    o_fwd_a_d_c = hit(i_regwrite_m, i_writereg_m, i_rs_d);
    o_fwd_b_d_c = hit(i_regwrite_m, i_writereg_m, i_rt_d);
    o_fwd_a_e_c = fwd_e(i_rs_e, i_regwrite_m, i_writereg_m, i_regwrite_w, i_writereg_w);
    o_fwd_b_e_c = fwd_e(i_rt_e, i_regwrite_m, i_writereg_m, i_regwrite_w, i_writereg_w);
  end

endmodule

// File: rtl/pipe_ctrl_scheduler.sv
// Pipeline control sequencer: ID/EX, EX/MEM, MEM/WB control registers, hazard
// stall/flush/forward controls and saturating stall/flush counters.
module pipe_ctrl_scheduler
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned ALU_OP_W = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                regwrite_d,
  input  logic                memtoreg_d,
  input  logic                memwrite_d,
  input  logic                alusrc_d,
  input  logic                regdst_d,
  input  logic                branch_d,
  input  logic                jump_d,
  input  logic [ALU_OP_W-1:0] alu_op_d,
  input  logic [REG_AW-1:0]   rs_d,
  input  logic [REG_AW-1:0]   rt_d,
  input  logic [REG_AW-1:0]   rd_d,
  input  logic                equal_d,
  output logic                pcsrc_d,
  output logic                jump_d_o,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic                forward_a_d,
  output logic                forward_b_d,
  output logic [1:0]          forward_a_e,
  output logic [1:0]          forward_b_e,
  output logic [REG_AW-1:0]   rs_e,
  output logic [REG_AW-1:0]   rt_e,
  output logic                regwrite_e,
  output logic                memtoreg_e,
  output logic                alusrc_e,
  output logic [ALU_OP_W-1:0] alu_op_e,
  output logic [REG_AW-1:0]   writereg_e,
  output logic [REG_AW-1:0]   writereg_m,
  output logic [REG_AW-1:0]   writereg_w,
  output logic                regwrite_m,
  output logic                memtoreg_m,
  output logic                memwrite_m,
  output logic                regwrite_w,
  output logic                memtoreg_w,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ex_ctrl_t            r_ctrl_e;
  logic [ALU_OP_W-1:0] r_alu_op_e;
  logic [REG_AW-1:0]   r_rs_e;
  logic [REG_AW-1:0]   r_rt_e;
  logic [REG_AW-1:0]   r_rd_e;

  logic                r_regwrite_m;
  logic                r_memtoreg_m;
  logic                r_memwrite_m;
  logic [REG_AW-1:0]   r_writereg_m;

  logic                r_regwrite_w;
  logic                r_memtoreg_w;
  logic [REG_AW-1:0]   r_writereg_w;

  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  ex_ctrl_t            w_ctrl_d;
  logic [REG_AW-1:0]   w_writereg_e;
  logic                w_stall;
  logic                w_flush_d;
  logic                w_pcsrc;
  logic                w_fwd_a_d;
  logic                w_fwd_b_d;
  logic [1:0]          w_fwd_a_e;
  logic [1:0]          w_fwd_b_e;

  always_comb begin
    w_ctrl_d          = '0;
    w_ctrl_d.regwrite = regwrite_d;
    w_ctrl_d.memtoreg = memtoreg_d;
    w_ctrl_d.memwrite = memwrite_d;
    w_ctrl_d.alusrc   = alusrc_d;
    w_ctrl_d.regdst   = regdst_d;
  end

  assign w_writereg_e = r_ctrl_e.regdst ? r_rd_e : r_rt_e;

  hazard_unit #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .i_branch_d   (branch_d),
    .i_jump_d     (jump_d),
    .i_equal_d    (equal_d),
    .i_rs_d       (rs_d),
    .i_rt_d       (rt_d),
    .i_rs_e       (r_rs_e),
    .i_rt_e       (r_rt_e),
    .i_regwrite_e (r_ctrl_e.regwrite),
    .i_memtoreg_e (r_ctrl_e.memtoreg),
    .i_writereg_e (w_writereg_e),
    .i_regwrite_m (r_regwrite_m),
    .i_memtoreg_m (r_memtoreg_m),
    .i_writereg_m (r_writereg_m),
    .i_regwrite_w (r_regwrite_w),
    .i_writereg_w (r_writereg_w),
    .o_pcsrc_d_c  (w_pcsrc),
    .o_stall_c    (w_stall),
    .o_flush_d_c  (w_flush_d),
    .o_fwd_a_d_c  (w_fwd_a_d),
    .o_fwd_b_d_c  (w_fwd_b_d),
    .o_fwd_a_e_c  (w_fwd_a_e),
    .o_fwd_b_e_c  (w_fwd_b_e)
  );

  // ID/EX: a stall leaves the instruction in ID, so EX receives a bubble
  always_ff @(posedge clk) begin
    if (rst || w_stall) begin
      r_ctrl_e   <= '0;
      r_alu_op_e <= '0;
      r_rs_e     <= '0;
      r_rt_e     <= '0;
      r_rd_e     <= '0;
    end else begin
      r_ctrl_e   <= w_ctrl_d;
      r_alu_op_e <= alu_op_d;
      r_rs_e     <= rs_d;
      r_rt_e     <= rt_d;
      r_rd_e     <= rd_d;
    end
  end

  // EX/MEM and MEM/WB never stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regwrite_m <= 1'b0;
      r_memtoreg_m <= 1'b0;
      r_memwrite_m <= 1'b0;
      r_writereg_m <= '0;
      r_regwrite_w <= 1'b0;
      r_memtoreg_w <= 1'b0;
      r_writereg_w <= '0;
    end else begin
      r_regwrite_m <= r_ctrl_e.regwrite;
      r_memtoreg_m <= r_ctrl_e.memtoreg;
      r_memwrite_m <= r_ctrl_e.memwrite;
      r_writereg_m <= w_writereg_e;
      r_regwrite_w <= r_regwrite_m;
      r_memtoreg_w <= r_memtoreg_m;
      r_writereg_w <= r_writereg_m;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_d && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign pcsrc_d     = w_pcsrc;
  assign jump_d_o    = jump_d && !w_stall;
  assign stall_f     = w_stall;
  assign stall_d     = w_stall;
  assign flush_e     = w_stall;
  assign flush_d     = w_flush_d;
  assign forward_a_d = w_fwd_a_d;
  assign forward_b_d = w_fwd_b_d;
  assign forward_a_e = w_fwd_a_e;
  assign forward_b_e = w_fwd_b_e;
  assign rs_e        = r_rs_e;
  assign rt_e        = r_rt_e;
  assign regwrite_e  = r_ctrl_e.regwrite;
  assign memtoreg_e  = r_ctrl_e.memtoreg;
  assign alusrc_e    = r_ctrl_e.alusrc;
  assign alu_op_e    = r_alu_op_e;
  assign writereg_e  = w_writereg_e;
  assign writereg_m  = r_writereg_m;
  assign writereg_w  = r_writereg_w;
  assign regwrite_m  = r_regwrite_m;
  assign memtoreg_m  = r_memtoreg_m;
  assign memwrite_m  = r_memwrite_m;
  assign regwrite_w  = r_regwrite_w;
  assign memtoreg_w  = r_memtoreg_w;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl_scheduler.sv
// Bench for pipe_ctrl_scheduler: vector table, directed hazard sequences and a
// random instruction stream checked against an instruction-level pipeline model.
module tb_pipe_ctrl_scheduler;
  import mips_pkg::*;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic regwrite, memtoreg, memwrite, alusrc, regdst, branch, jump;
    logic [ALU_OP_W-1:0] alu_op;
    logic [REG_AW-1:0]   rs, rt, rd;
  } instr_t;

  typedef struct packed {
    logic pcsrc, jump_o, stall_f, stall_d, flush_d, flush_e, fad, fbd;
    logic [1:0] fae, fbe;
    logic [REG_AW-1:0] rs_e, rt_e;
    logic rw_e, mr_e, as_e;
    logic [ALU_OP_W-1:0] aluop_e;
    logic [REG_AW-1:0] wr_e, wr_m, wr_w;
    logic rw_m, mr_m, mw_m, rw_w, mr_w;
    logic [CNT_W-1:0] scnt, fcnt;
  } outs_t;

  typedef struct {
    instr_t prev;
    instr_t cur;
    logic   eq;
    logic   stall;
    logic   flush_d;
    logic   pcsrc;
    logic   jump_o;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst;
  instr_t id_i;
  logic   eq_i;

  logic pcsrc_d, jump_d_o, stall_f, stall_d, flush_d, flush_e, forward_a_d, forward_b_d;
  logic [1:0] forward_a_e, forward_b_e;
  logic [REG_AW-1:0] rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic regwrite_e, memtoreg_e, alusrc_e, regwrite_m, memtoreg_m, memwrite_m, regwrite_w, memtoreg_w;
  logic [ALU_OP_W-1:0] alu_op_e;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the instruction records occupying EX, MEM and WB
  instr_t m_ex, m_mem, m_wb;
  int unsigned m_scnt = 0;
  int unsigned m_fcnt = 0;

  always #5 clk = ~clk;

  pipe_ctrl_scheduler #(
    .REG_AW(REG_AW), .ALU_OP_W(ALU_OP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .regwrite_d(id_i.regwrite), .memtoreg_d(id_i.memtoreg), .memwrite_d(id_i.memwrite),
    .alusrc_d(id_i.alusrc), .regdst_d(id_i.regdst), .branch_d(id_i.branch), .jump_d(id_i.jump),
    .alu_op_d(id_i.alu_op), .rs_d(id_i.rs), .rt_d(id_i.rt), .rd_d(id_i.rd), .equal_d(eq_i),
    .pcsrc_d(pcsrc_d), .jump_d_o(jump_d_o), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .rs_e(rs_e), .rt_e(rt_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .alusrc_e(alusrc_e), .alu_op_e(alu_op_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m),
    .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic instr_t mk_r(int rd, int rs, int rt, logic [ALU_OP_W-1:0] op);
    instr_t i = '0;
    i.regwrite = 1'b1; i.regdst = 1'b1; i.alu_op = op;
    i.rd = REG_AW'(rd); i.rs = REG_AW'(rs); i.rt = REG_AW'(rt);
    return i;
  endfunction

  function automatic instr_t mk_lw(int rt, int rs);
    instr_t i = '0;
    i.regwrite = 1'b1; i.memtoreg = 1'b1; i.alusrc = 1'b1; i.alu_op = ALUOP_ADD;
    i.rt = REG_AW'(rt); i.rs = REG_AW'(rs); i.rd = REG_AW'(rt + 3);
    return i;
  endfunction

  function automatic instr_t mk_beq(int rs, int rt);
    instr_t i = '0;
    i.branch = 1'b1; i.alu_op = ALUOP_SUB; i.rs = REG_AW'(rs); i.rt = REG_AW'(rt);
    return i;
  endfunction

  function automatic instr_t mk_j();
    instr_t i = '0;
    i.jump = 1'b1;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i = '0;
    logic [31:0] rv;
    int a, b, c;
    a = int'($urandom_range(0, 7)); b = int'($urandom_range(0, 7)); c = int'($urandom_range(0, 7));
    case ($urandom_range(0, 6))
      0: i = mk_r(a, b, c, ALUOP_FUNCT);
      1: i = mk_lw(a, b);
      2: begin i.memwrite = 1'b1; i.alusrc = 1'b1; i.rs = REG_AW'(a); i.rt = REG_AW'(b); end
      3: i = mk_beq(a, b);
      4: begin i.regwrite = 1'b1; i.alusrc = 1'b1; i.rs = REG_AW'(a); i.rt = REG_AW'(b); end
      5: i = mk_j();
      default: begin rv = $urandom; i = rv[$bits(instr_t)-1:0]; end
    endcase
    return i;
  endfunction

  function automatic logic [REG_AW-1:0] dest(instr_t i);
    return i.regdst ? i.rd : i.rt;
  endfunction

  function automatic logic dep(logic wr, logic [REG_AW-1:0] d, logic [REG_AW-1:0] r);
    return wr && (r != 0) && (d == r);
  endfunction

  function automatic logic model_stall();
    logic lw, br;
    lw = dep(m_ex.memtoreg, m_ex.rt, id_i.rs) || dep(m_ex.memtoreg, m_ex.rt, id_i.rt);
    br = id_i.branch &&
         (dep(m_ex.regwrite, dest(m_ex), id_i.rs) || dep(m_ex.regwrite, dest(m_ex), id_i.rt) ||
          dep(m_mem.memtoreg, dest(m_mem), id_i.rs) || dep(m_mem.memtoreg, dest(m_mem), id_i.rt));
    return lw || br;
  endfunction

  function automatic logic [1:0] model_fwd(logic [REG_AW-1:0] r);
    if (dep(m_mem.regwrite, dest(m_mem), r)) return 2'b10;
    if (dep(m_wb.regwrite, dest(m_wb), r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic outs_t model_out();
    outs_t o;
    logic s;
    s = model_stall();
    o = '0;
    o.pcsrc = id_i.branch & eq_i;
    o.jump_o = id_i.jump & ~s;
    o.stall_f = s; o.stall_d = s; o.flush_e = s;
    o.flush_d = (o.pcsrc | id_i.jump) & ~s;
    o.fad = dep(m_mem.regwrite, dest(m_mem), id_i.rs);
    o.fbd = dep(m_mem.regwrite, dest(m_mem), id_i.rt);
    o.fae = model_fwd(m_ex.rs);
    o.fbe = model_fwd(m_ex.rt);
    o.rs_e = m_ex.rs; o.rt_e = m_ex.rt;
    o.rw_e = m_ex.regwrite; o.mr_e = m_ex.memtoreg; o.as_e = m_ex.alusrc; o.aluop_e = m_ex.alu_op;
    o.wr_e = dest(m_ex); o.wr_m = dest(m_mem); o.wr_w = dest(m_wb);
    o.rw_m = m_mem.regwrite; o.mr_m = m_mem.memtoreg; o.mw_m = m_mem.memwrite;
    o.rw_w = m_wb.regwrite; o.mr_w = m_wb.memtoreg;
    o.scnt = CNT_W'(m_scnt); o.fcnt = CNT_W'(m_fcnt);
    return o;
  endfunction

  function automatic outs_t dut_out();
    outs_t o;
    o.pcsrc = pcsrc_d; o.jump_o = jump_d_o; o.stall_f = stall_f; o.stall_d = stall_d;
    o.flush_d = flush_d; o.flush_e = flush_e; o.fad = forward_a_d; o.fbd = forward_b_d;
    o.fae = forward_a_e; o.fbe = forward_b_e; o.rs_e = rs_e; o.rt_e = rt_e;
    o.rw_e = regwrite_e; o.mr_e = memtoreg_e; o.as_e = alusrc_e; o.aluop_e = alu_op_e;
    o.wr_e = writereg_e; o.wr_m = writereg_m; o.wr_w = writereg_w;
    o.rw_m = regwrite_m; o.mr_m = memtoreg_m; o.mw_m = memwrite_m;
    o.rw_w = regwrite_w; o.mr_w = memtoreg_w; o.scnt = stall_cnt; o.fcnt = flush_cnt;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_all();
    outs_t a, e;
    a = dut_out();
    e = model_out();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL all_outputs @%0t: got %h expected %h", $time, a, e);
    end
  endtask

  // Advance the model across one rising edge, using the inputs held before it
  task automatic model_edge();
    outs_t o;
    logic s;
    o = model_out();
    s = model_stall();
    if (rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_scnt = 0; m_fcnt = 0;
    end else begin
      m_wb = m_mem;
      m_mem = m_ex;
      m_ex = s ? instr_t'('0) : id_i;
      if (s && m_scnt < CNT_MAX) m_scnt++;
      if (o.flush_d && m_fcnt < CNT_MAX) m_fcnt++;
    end
  endtask

  task automatic present(input instr_t i, input logic e, input logic r);
    id_i = i; eq_i = e; rst = r;
    @(negedge clk);
    chk_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    present(instr_t'('0), 1'b0, 1'b1);
    advance();
  endtask

  vec_t tbl[10];
  instr_t nop;
  instr_t cur;
  logic hold, r;

  initial begin
    nop = '0;
    tbl[0] = '{mk_lw(8, 1), mk_r(9, 8, 8, ALUOP_FUNCT), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{mk_lw(8, 1), mk_r(9, 3, 8, ALUOP_FUNCT), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{mk_lw(8, 1), mk_r(9, 3, 4, ALUOP_FUNCT), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{mk_lw(0, 1), mk_r(9, 0, 0, ALUOP_FUNCT), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{mk_r(8, 1, 2, ALUOP_FUNCT), mk_beq(8, 0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{mk_r(8, 1, 2, ALUOP_FUNCT), mk_beq(3, 4), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{nop, mk_j(), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{mk_lw(5, 1), mk_j(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{mk_r(8, 1, 2, ALUOP_FUNCT), mk_r(9, 8, 8, ALUOP_FUNCT), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{mk_lw(5, 1), mk_beq(5, 5), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held two cycles with random inputs; first edge establishes a known state
    id_i = rand_instr(); eq_i = 1'($urandom_range(0, 1)); rst = 1'b1;
    advance();
    present(rand_instr(), 1'($urandom_range(0, 1)), 1'b1);
    chk("rst_stall_f", 32'(stall_f), 0);
    chk("rst_fwd_a_e", 32'(forward_a_e), 0);
    chk("rst_regwrite_w", 32'(regwrite_w), 0);
    chk("rst_writereg_m", 32'(writereg_m), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    advance();

    for (int k = 0; k < 10; k++) begin
      do_reset();
      present(tbl[k].prev, 1'b0, 1'b0);
      advance();
      present(tbl[k].cur, tbl[k].eq, 1'b0);
      chk($sformatf("tbl%0d_stall", k), 32'(stall_d), 32'(tbl[k].stall));
      chk($sformatf("tbl%0d_flush_d", k), 32'(flush_d), 32'(tbl[k].flush_d));
      chk($sformatf("tbl%0d_pcsrc", k), 32'(pcsrc_d), 32'(tbl[k].pcsrc));
      chk($sformatf("tbl%0d_jump_o", k), 32'(jump_d_o), 32'(tbl[k].jump_o));
      advance();
    end

    // lw $8 ; add $9,$8,$8
    do_reset();
    present(mk_lw(8, 1), 1'b0, 1'b0); chk("lu_c0_stall", 32'(stall_f), 0); advance();
    present(mk_r(9, 8, 8, ALUOP_FUNCT), 1'b0, 1'b0);
    chk("lu_c1_stall_f", 32'(stall_f), 1); chk("lu_c1_flush_e", 32'(flush_e), 1); advance();
    present(mk_r(9, 8, 8, ALUOP_FUNCT), 1'b0, 1'b0); chk("lu_c2_stall_d", 32'(stall_d), 0); advance();
    present(nop, 1'b0, 1'b0);
    chk("lu_fwd_a_e", 32'(forward_a_e), 1); chk("lu_fwd_b_e", 32'(forward_b_e), 1);
    chk("lu_stall_cnt", 32'(stall_cnt), 1); advance();

    // add $8 ; sub $9,$8,$3  then  add $8 ; add $10 ; sub $9,$8,$3
    do_reset();
    present(mk_r(8, 1, 2, ALUOP_FUNCT), 1'b0, 1'b0); advance();
    present(mk_r(9, 8, 3, ALUOP_SUB), 1'b0, 1'b0); chk("ex_no_stall", 32'(stall_f), 0); advance();
    present(nop, 1'b0, 1'b0);
    chk("ex_fwd_a_mem", 32'(forward_a_e), 2); chk("ex_fwd_b_rf", 32'(forward_b_e), 0); advance();
    do_reset();
    present(mk_r(8, 1, 2, ALUOP_FUNCT), 1'b0, 1'b0); advance();
    present(mk_r(10, 1, 2, ALUOP_FUNCT), 1'b0, 1'b0); advance();
    present(mk_r(9, 8, 3, ALUOP_SUB), 1'b0, 1'b0); advance();
    present(nop, 1'b0, 1'b0); chk("ex_fwd_a_wb", 32'(forward_a_e), 1); advance();

    // add $8 ; beq $8,$0 taken
    do_reset();
    present(mk_r(8, 1, 2, ALUOP_FUNCT), 1'b0, 1'b0); advance();
    present(mk_beq(8, 0), 1'b1, 1'b0);
    chk("br_c1_stall", 32'(stall_d), 1); chk("br_c1_flush_d", 32'(flush_d), 0); advance();
    present(mk_beq(8, 0), 1'b1, 1'b0);
    chk("br_c2_stall", 32'(stall_d), 0); chk("br_c2_fwd_a_d", 32'(forward_a_d), 1);
    chk("br_c2_pcsrc", 32'(pcsrc_d), 1); chk("br_c2_flush_d", 32'(flush_d), 1); advance();
    present(nop, 1'b0, 1'b0); chk("br_flush_cnt", 32'(flush_cnt), 1); advance();

    // lw $5 ; beq $5,$5 taken: two stall cycles, redirect deferred
    do_reset();
    present(mk_lw(5, 1), 1'b0, 1'b0); advance();
    for (int c = 1; c <= 2; c++) begin
      present(mk_beq(5, 5), 1'b1, 1'b0);
      chk($sformatf("lb_c%0d_stall", c), 32'(stall_f), 1);
      chk($sformatf("lb_c%0d_flush_d", c), 32'(flush_d), 0);
      advance();
    end
    present(mk_beq(5, 5), 1'b1, 1'b0);
    chk("lb_c3_stall", 32'(stall_f), 0); chk("lb_c3_flush_d", 32'(flush_d), 1); advance();
    present(nop, 1'b0, 1'b0); chk("lb_stall_cnt", 32'(stall_cnt), 2); advance();

    // $0 producer never forwards
    do_reset();
    present(mk_r(0, 1, 2, ALUOP_FUNCT), 1'b0, 1'b0); advance();
    present(mk_r(9, 0, 0, ALUOP_FUNCT), 1'b0, 1'b0); advance();
    present(nop, 1'b0, 1'b0);
    chk("z_fwd_a_e", 32'(forward_a_e), 0); chk("z_fwd_b_e", 32'(forward_b_e), 0); advance();

    // Counter saturation: 300 load-use stalls and 300 jump flushes
    do_reset();
    for (int k = 0; k < 300; k++) begin
      present(mk_lw(5, 1), 1'b0, 1'b0); advance();
      present(mk_r(6, 5, 5, ALUOP_FUNCT), 1'b0, 1'b0); advance();
      present(mk_r(6, 5, 5, ALUOP_FUNCT), 1'b0, 1'b0); advance();
      present(mk_j(), 1'b0, 1'b0); advance();
    end
    present(nop, 1'b0, 1'b0);
    chk("sat_stall_cnt", 32'(stall_cnt), CNT_MAX);
    chk("sat_flush_cnt", 32'(flush_cnt), CNT_MAX);
    advance();

    // Random stream; the bench acts as IF/ID and re-presents a stalled instruction
    do_reset();
    cur = rand_instr();
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 99) == 0);
      present(cur, 1'($urandom_range(0, 1)), r);
      hold = model_stall() && !r;
      advance();
      if (!hold) cur = rand_instr();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
